tx_framer: RTL and testbench

//  ISO/IEC 14443-3A PICC transmit framer: sits directly upstream of tx (14443-2A Manchester/subcarrier stage).

---
 rtl/iso14443a_pkg.sv | 19 +
 rtl/tx_framer_crc_a.sv | 33 +++
 rtl/tx_framer.sv | 184 ++++++++++++++++++
 tb/tb_tx_framer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iso14443a_pkg.sv
// Shared ISO/IEC 14443-3A definitions: CRC_A constants and transmit framer state encoding.
// CRC states exist only when TX_FRAMER_CRC_EN is defined.
package iso14443a_pkg;

  localparam logic [15:0] CRC_A_INIT           = 16'h6363;
  localparam logic [15:0] CRC_A_POLY_REFLECTED = 16'h8408;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY
`ifdef TX_FRAMER_CRC_EN
    ,
    CRC_DATA,
    CRC_PARITY
`endif
  } tx_framer_state_t;

endpackage

// File: rtl/tx_framer_crc_a.sv
// Bit-serial CRC_A (reflected, LSB first), present only when TX_FRAMER_CRC_EN is defined.
`ifdef TX_FRAMER_CRC_EN
module crc_a
  import iso14443a_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = CRC_A_INIT;
    end else if (en) begin
      crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ bit_in) ? CRC_A_POLY_REFLECTED : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_A_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule
`endif

// File: rtl/tx_framer.sv
// ISO/IEC 14443-3A PICC transmit framer: bytes in, LSB-first bits with odd parity out.
// Define TX_FRAMER_CRC_EN to add the in_append_crc port and CRC_A trailer generation.
module tx_framer
  import iso14443a_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_data_valid,
  input  logic       in_last,
  input  logic [2:0] in_data_bits,
`ifdef TX_FRAMER_CRC_EN
  input  logic       in_append_crc,
`endif
  output logic       in_req,
  output logic       out_data,
  output logic       out_data_valid,
  output logic       out_last,
  input  logic       out_req
);

  tx_framer_state_t state_q, state_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic [2:0] nbits_q, nbits_d;
  logic       par_q, par_d;
  logic       last_q, last_d;

`ifdef TX_FRAMER_CRC_EN
  logic        crc_app_q, crc_app_d;
  logic        crc_hi_q, crc_hi_d;
  logic        crc_en;
  logic [15:0] crc;

  crc_a u_crc_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state_q == IDLE),
    .en     (crc_en),
    .bit_in (shift_q[0]),
    .crc    (crc)
  );
`endif

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    nbits_d  = nbits_q;
    par_d    = par_q;
    last_d   = last_q;
    in_req   = 1'b0;
    out_data = 1'b0;
    out_last = 1'b0;
`ifdef TX_FRAMER_CRC_EN
    crc_app_d = crc_app_q;
    crc_hi_d  = crc_hi_q;
    crc_en    = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (in_data_valid) begin
          in_req  = 1'b1;
          state_d = DATA;
`ifdef TX_FRAMER_CRC_EN
          crc_app_d = in_append_crc;
`endif
        end
      end

      DATA: begin
        out_data = shift_q[0];
        out_last = last_q && (nbits_q != 3'd0) && (cnt_q == nbits_q - 3'd1);
        if (out_req) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          par_d   = par_q ^ shift_q[0];
`ifdef TX_FRAMER_CRC_EN
          crc_en  = 1'b1;
`endif
          if (out_last)              state_d = IDLE;
          else if (cnt_q == 3'd7)    state_d = PARITY;
        end
      end

      PARITY: begin
        out_data = ~par_q;
`ifdef TX_FRAMER_CRC_EN
        out_last = last_q && !crc_app_q;
`else
        out_last = last_q;
`endif
        if (out_req) begin
          if (last_q) begin
            state_d = IDLE;
`ifdef TX_FRAMER_CRC_EN
            if (crc_app_q) begin
              shift_d  = crc[7:0];
              cnt_d    = '0;
              par_d    = 1'b0;
              crc_hi_d = 1'b0;
              state_d  = CRC_DATA;
            end
`endif
          end else if (in_data_valid) begin
            // Reload in the same cycle the parity bit is consumed: no gap in out_data_valid.
            in_req  = 1'b1;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end

`ifdef TX_FRAMER_CRC_EN
      CRC_DATA: begin
        out_data = shift_q[0];
        if (out_req) begin
          shift_d = {1'b0, shift_q[7:1]};
          cnt_d   = cnt_q + 3'd1;
          par_d   = par_q ^ shift_q[0];
          if (cnt_q == 3'd7) state_d = CRC_PARITY;
        end
      end

      CRC_PARITY: begin
        out_data = ~par_q;
        out_last = crc_hi_q;
        if (out_req) begin
          if (crc_hi_q) begin
            state_d = IDLE;
          end else begin
            shift_d  = crc[15:8];
            cnt_d    = '0;
            par_d    = 1'b0;
            crc_hi_d = 1'b1;
            state_d  = CRC_DATA;
          end
        end
      end
`endif

      default: state_d = IDLE;
    endcase

    if (in_req) begin
      shift_d = in_data;
      cnt_d   = '0;
      par_d   = 1'b0;
      last_d  = in_last;
      nbits_d = in_data_bits;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
      nbits_q <= '0;
      par_q   <= 1'b0;
      last_q  <= 1'b0;
`ifdef TX_FRAMER_CRC_EN
      crc_app_q <= 1'b0;
      crc_hi_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      nbits_q <= nbits_d;
      par_q   <= par_d;
      last_q  <= last_d;
`ifdef TX_FRAMER_CRC_EN
      crc_app_q <= crc_app_d;
      crc_hi_q  <= crc_hi_d;
`endif
    end
  end

  assign out_data_valid = (state_q != IDLE);

endmodule

// File: tb/tb_tx_framer.sv
// Directed, table-driven bench for tx_framer; CRC_A rows are added when TX_FRAMER_CRC_EN is defined.
module tb_tx_framer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_data_valid;
  logic       in_last;
  logic [2:0] in_data_bits;
`ifdef TX_FRAMER_CRC_EN
  logic       in_append_crc;
`endif
  logic       in_req;
  logic       out_data;
  logic       out_data_valid;
  logic       out_last;
  logic       out_req;

  int n_tests = 0;
  int n_fail  = 0;
  int req_cnt = 0;

  always #5 clk = ~clk;

  tx_framer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_data        (in_data),
    .in_data_valid  (in_data_valid),
    .in_last        (in_last),
    .in_data_bits   (in_data_bits),
`ifdef TX_FRAMER_CRC_EN
    .in_append_crc  (in_append_crc),
`endif
    .in_req         (in_req),
    .out_data       (out_data),
    .out_data_valid (out_data_valid),
    .out_last       (out_last),
    .out_req        (out_req)
  );

  always @(negedge clk) if (in_req) req_cnt++;

  typedef struct {
    logic [31:0] bytes;    // byte i at [8*i +: 8]
    int          nbytes;
    logic [2:0]  nbits;
    logic        crc;
    string       exp;      // transmitted bits in order
    int          exp_req;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [31:0] b, int n, logic [2:0] nb, logic crc, string exp, int req);
    vec_t v;
    v.bytes = b; v.nbytes = n; v.nbits = nb; v.crc = crc; v.exp = exp; v.exp_req = req;
    return v;
  endfunction

  task automatic chk_s(string name, string act, string exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", name, act, exp);
    end
  endtask

  task automatic chk_i(string name, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic feed(input vec_t v, input int withhold_from, output bit to);
    int k;
    to = 1'b0;
    for (int i = 0; i < v.nbytes && i < withhold_from; i++) begin
      in_data       = v.bytes[8*i +: 8];
      in_last       = (i == v.nbytes - 1);
      in_data_bits  = v.nbits;
`ifdef TX_FRAMER_CRC_EN
      in_append_crc = (i == 0) ? v.crc : 1'b0;
`endif
      in_data_valid = 1'b1;
      k = 0;
      @(negedge clk); #2;
      while (!in_req && k < 3000) begin
        @(negedge clk); #2;
        k++;
      end
      if (!in_req) begin
        to = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    in_data_valid = 1'b0;
    in_last       = 1'b0;
  endtask

  task automatic recv(input int gap, input int stall_at, input int stall_len,
                      output string bits, output int last_idx, output int last_cnt,
                      output bit stall_err, output bit to);
    int  k;
    logic d, v, l;
    bits = ""; last_idx = -1; last_cnt = 0; stall_err = 1'b0; to = 1'b0;
    k = 0;
    @(posedge clk); #1;
    while (!out_data_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_data_valid) begin
      to = 1'b1;
      return;
    end
    for (int n = 0; n < 200; n++) begin
      if (n == stall_at) begin
        d = out_data; v = out_data_valid; l = out_last;
        repeat (stall_len) begin
          @(posedge clk); #1;
          if (out_data !== d || out_data_valid !== v || out_last !== l) stall_err = 1'b1;
        end
      end
      repeat (gap) begin
        @(posedge clk); #1;
      end
      if (out_data) bits = {bits, "1"};
      else          bits = {bits, "0"};
      if (out_last) begin
        last_cnt++;
        last_idx = n;
      end
      out_req = 1'b1;
      @(posedge clk); #1;
      out_req = 1'b0;
      if (!out_data_valid) return;
    end
    to = 1'b1;
  endtask

  task automatic run_frame(input string tag, input vec_t v, input int gap, input int withhold_from,
                           input int stall_at, input int stall_len, input int exp_last_idx);
    string bits;
    int    last_idx, last_cnt, req0;
    bit    stall_err, fto, rto;
    req0 = req_cnt;
    fork
      feed(v, withhold_from, fto);
      recv(gap, stall_at, stall_len, bits, last_idx, last_cnt, stall_err, rto);
    join
    chk_i({tag, " timeout"}, int'(fto | rto), 0);
    chk_s({tag, " bits"}, bits, v.exp);
    chk_i({tag, " last_idx"}, last_idx, exp_last_idx);
    chk_i({tag, " last_cnt"}, last_cnt, (exp_last_idx < 0) ? 0 : 1);
    chk_i({tag, " in_req"}, req_cnt - req0, v.exp_req);
    chk_i({tag, " valid_end"}, int'(out_data_valid), 0);
    if (stall_len > 0) chk_i({tag, " stall_stable"}, int'(stall_err), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs.push_back(mk(32'h0000_0026, 1, 3'd7, 1'b0, "0110010", 1));
    vecs.push_back(mk(32'h0000_2093, 2, 3'd0, 1'b0, "110010011000001000", 2));
    vecs.push_back(mk(32'h0000_0000, 1, 3'd0, 1'b0, "000000001", 1));
    vecs.push_back(mk(32'h0000_00FF, 1, 3'd0, 1'b0, "111111111", 1));
    vecs.push_back(mk(32'h0000_0001, 1, 3'd1, 1'b0, "1", 1));
    vecs.push_back(mk(32'h0000_3CA5, 2, 3'd4, 1'b0, "1010010110011", 2));
`ifdef TX_FRAMER_CRC_EN
    vecs.push_back(mk(32'h0000_0050, 2, 3'd0, 1'b1,
                      "000010101000000001111010100101100110", 2));
    vecs.push_back(mk(32'h0000_0026, 1, 3'd7, 1'b1, "0110010", 1));
`endif

    rst_n = 1'b0; in_data = '0; in_data_valid = 1'b0; in_last = 1'b0;
    in_data_bits = '0; out_req = 1'b0;
`ifdef TX_FRAMER_CRC_EN
    in_append_crc = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk_i("reset out_data_valid", int'(out_data_valid), 0);
    chk_i("reset out_data", int'(out_data), 0);
    chk_i("reset out_last", int'(out_last), 0);
    chk_i("reset in_req", int'(in_req), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // out_req while idle has no effect
    out_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    out_req = 1'b0;
    chk_i("idle out_req ignored", int'(out_data_valid), 0);

    foreach (vecs[i]) begin
      v = vecs[i];
      run_frame($sformatf("vec%0d", i), v, i % 3, 99, -1, 0, v.exp.len() - 1);
    end

    // tx stall mid-byte
    run_frame("stall", vecs[1], 0, 99, 4, 500, 17);

    // underrun: second byte never offered
    v = mk(32'h0000_2093, 2, 3'd0, 1'b0, "110010011", 1);
    run_frame("underrun", v, 1, 1, -1, 0, -1);
    repeat (5) @(posedge clk);
    #1;
    chk_i("underrun stays idle", int'(out_data_valid), 0);

    // reset after 5 bits of a frame
    in_data = 8'h93; in_last = 1'b0; in_data_bits = '0; in_data_valid = 1'b1;
    @(posedge clk); #1;
    in_data_valid = 1'b0;
    repeat (5) begin
      out_req = 1'b1;
      @(posedge clk); #1;
      out_req = 1'b0;
    end
    chk_i("midframe valid before reset", int'(out_data_valid), 1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    chk_i("midframe reset valid", int'(out_data_valid), 0);
    chk_i("midframe reset data", int'(out_data), 0);
    chk_i("midframe reset last", int'(out_last), 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_frame("after_reset", vecs[0], 0, 99, -1, 0, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
